// File: rtl/rp_8bit_uart_pkg.sv
// Shared definitions for the rp_8bit UART: register offsets, STA/CTL bit
// positions and the transmit/receive state encodings.
package rp_8bit_uart_pkg;

  localparam logic [1:0] OFF_DAT = 2'd0;
  localparam logic [1:0] OFF_STA = 2'd1;
  localparam logic [1:0] OFF_CTL = 2'd2;
  localparam logic [1:0] OFF_BDR = 2'd3;

  localparam int STA_TX_FULL  = 0;
  localparam int STA_TX_EMPTY = 1;
  localparam int STA_RX_AVAIL = 2;
  localparam int STA_RX_OVR   = 3;
  localparam int STA_FRM_ERR  = 4;
  localparam int STA_TX_BUSY  = 5;
  localparam int STA_TX_OVF   = 6;

  localparam int CTL_TXEN = 0;
  localparam int CTL_RXEN = 1;
  localparam int CTL_TIE  = 2;
  localparam int CTL_RIE  = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/rp_8bit_fifo.sv
// Synchronous FIFO; a pop on empty is ignored, so a push into an empty FIFO is
// never bypassed to the read side. Push while full succeeds only alongside a pop.
module rp_8bit_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q, rptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rp_8bit_uart.sv
// 8N1 UART on the rp_8bit I/O bus: DAT/STA/CTL/BDR at BASE..BASE+3, FIFO-buffered
// TX and RX, registered read data and level interrupts.
module rp_8bit_uart
  import rp_8bit_uart_pkg::*;
#(
  parameter logic [5:0] BASE = 6'h10,
  parameter int         TFD  = 4,
  parameter int         RFD  = 4,
  parameter logic [7:0] BDR0 = 8'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_wen,
  input  logic       io_ren,
  input  logic [5:0] io_adr,
  input  logic [7:0] io_wdt,
  input  logic [7:0] io_msk,
  output logic [7:0] io_rdt,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       irq_tx,
  output logic       irq_rx
);

  logic [3:0] ctl_q, ctl_d;
  logic [7:0] bdr_q, bdr_d, rdt_q, rdt_d, sta;
  logic       tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d;
  logic       irq_tx_q, irq_rx_q;

  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_cnt_q, tx_cnt_d, tx_sh_q, tx_sh_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       txd_q, txd_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] rx_cnt_q, rx_cnt_d, rx_sh_q, rx_sh_d, rx_half_load;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_s1_q, rx_s2_q, rx_prev_q, frm_set, ovr_set;
  logic [8:0] rx_half;

  logic       sel, wr_dat, wr_sta, wr_ctl, wr_bdr;
  logic       tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_rdata, rx_rdata;

  assign sel     = (io_adr[5:2] == BASE[5:2]);
  assign wr_dat  = io_wen & sel & (io_adr[1:0] == OFF_DAT);
  assign wr_sta  = io_wen & sel & (io_adr[1:0] == OFF_STA);
  assign wr_ctl  = io_wen & sel & (io_adr[1:0] == OFF_CTL);
  assign wr_bdr  = io_wen & sel & (io_adr[1:0] == OFF_BDR);
  assign tx_push = wr_dat & (|io_msk);
  assign rx_pop  = io_ren & sel & (io_adr[1:0] == OFF_DAT);

  rp_8bit_fifo #(.DW(8), .DEPTH(TFD)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .wdata_i(io_wdt), .pop_i(tx_pop),
    .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty)
  );

  rp_8bit_fifo #(.DW(8), .DEPTH(RFD)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .wdata_i(rx_sh_q), .pop_i(rx_pop),
    .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sta = '0;
    sta[STA_TX_FULL]  = tx_full;
    sta[STA_TX_EMPTY] = tx_empty;
    sta[STA_RX_AVAIL] = ~rx_empty;
    sta[STA_RX_OVR]   = rx_ovr_q;
    sta[STA_FRM_ERR]  = frm_err_q;
    sta[STA_TX_BUSY]  = (tx_state_q != TX_IDLE);
    sta[STA_TX_OVF]   = tx_ovf_q;

    rdt_d = '0;
    if (io_ren && sel) begin
      unique case (io_adr[1:0])
        OFF_DAT: rdt_d = rx_empty ? 8'h00 : rx_rdata;
        OFF_STA: rdt_d = sta;
        OFF_CTL: rdt_d = {4'b0, ctl_q};
        default: rdt_d = bdr_q;
      endcase
    end

    ctl_d = wr_ctl ? ((ctl_q & ~io_msk[3:0]) | (io_wdt[3:0] & io_msk[3:0])) : ctl_q;
    bdr_d = wr_bdr ? ((bdr_q & ~io_msk) | (io_wdt & io_msk)) : bdr_q;
    // A flag raised in the same cycle as its W1C clear stays set.
    tx_ovf_d  = (tx_ovf_q  & ~(wr_sta & io_wdt[STA_TX_OVF]  & io_msk[STA_TX_OVF]))
              | (tx_push & tx_full & ~tx_pop);
    rx_ovr_d  = (rx_ovr_q  & ~(wr_sta & io_wdt[STA_RX_OVR]  & io_msk[STA_RX_OVR]))  | ovr_set;
    frm_err_d = (frm_err_q & ~(wr_sta & io_wdt[STA_FRM_ERR] & io_msk[STA_FRM_ERR])) | frm_set;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: if (ctl_q[CTL_TXEN] && !tx_empty) begin
        tx_pop = 1'b1; tx_sh_d = tx_rdata; tx_cnt_d = bdr_q; tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == 8'd0) begin
        tx_cnt_d = bdr_q; tx_bit_d = 3'd0; tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q - 8'd1;
      TX_DATA: if (tx_cnt_q == 8'd0) begin
        tx_cnt_d = bdr_q;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        else begin tx_bit_d = tx_bit_q + 3'd1; tx_sh_d = {1'b0, tx_sh_q[7:1]}; end
      end else tx_cnt_d = tx_cnt_q - 8'd1;
      default: if (tx_cnt_q == 8'd0) begin
        if (ctl_q[CTL_TXEN] && !tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_rdata; tx_cnt_d = bdr_q; tx_state_d = TX_START;
        end else tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q - 8'd1;
    endcase
    // The line level is derived from the next state so uart_txd comes straight from a flop.
    txd_d = (tx_state_d == TX_START) ? 1'b0 : (tx_state_d == TX_DATA) ? tx_sh_d[0] : 1'b1;
  end

  assign rx_half      = ({1'b0, bdr_q} + 9'd1) >> 1;
  assign rx_half_load = (rx_half == 9'd0) ? 8'd0 : 8'(rx_half - 9'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    frm_set    = 1'b0;
    ovr_set    = 1'b0;
    if (!ctl_q[CTL_RXEN]) rx_state_d = RX_IDLE;
    else begin
      unique case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d = rx_half_load; rx_state_d = RX_START;
        end
        RX_START: if (rx_cnt_q == 8'd0) begin
          if (rx_s2_q) rx_state_d = RX_IDLE;
          else begin rx_cnt_d = bdr_q; rx_bit_d = 3'd0; rx_state_d = RX_DATA; end
        end else rx_cnt_d = rx_cnt_q - 8'd1;
        RX_DATA: if (rx_cnt_q == 8'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = bdr_q;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 8'd1;
        default: if (rx_cnt_q == 8'd0) begin
          rx_state_d = RX_IDLE;
          if (!rx_s2_q) frm_set = 1'b1;
          else if (rx_full && !rx_pop) ovr_set = 1'b1;
          else rx_push = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 8'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctl_q      <= '0;
      bdr_q      <= BDR0;
      rdt_q      <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      frm_err_q  <= 1'b0;
      irq_tx_q   <= 1'b0;
      irq_rx_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ctl_q      <= ctl_d;
      bdr_q      <= bdr_d;
      rdt_q      <= rdt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovr_q   <= rx_ovr_d;
      frm_err_q  <= frm_err_d;
      irq_tx_q   <= ctl_q[CTL_TIE] & tx_empty;
      irq_rx_q   <= ctl_q[CTL_RIE] & ~rx_empty;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= uart_rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

  assign io_rdt   = rdt_q;
  assign uart_txd = txd_q;
  assign irq_tx   = irq_tx_q;
  assign irq_rx   = irq_rx_q;

endmodule

// File: tb/tb_rp_8bit_uart.sv
// Self-checking bench for rp_8bit_uart: register vectors from a table, then
// serial TX/RX sequences; read data is checked through an expected-value queue.
module tb_rp_8bit_uart;

  localparam logic [5:0] A_DAT = 6'h10;
  localparam logic [5:0] A_STA = 6'h11;
  localparam logic [5:0] A_CTL = 6'h12;
  localparam logic [5:0] A_BDR = 6'h13;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_wen, io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt, io_msk, io_rdt;
  logic       uart_txd, uart_rxd, irq_tx, irq_rx;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic       drv_chk = 1'b0;
  logic       chk_pend = 1'b0;
  logic [7:0] exp_q [$];
  string      name_q [$];

  typedef struct {
    logic       wen;
    logic       ren;
    logic [5:0] adr;
    logic [7:0] wdt;
    logic [7:0] msk;
    logic [7:0] exp;
    string      name;
  } vec_t;

  rp_8bit_uart #(.BASE(6'h10), .TFD(4), .RFD(4), .BDR0(8'd15)) dut (
    .clk(clk), .rst(rst), .io_wen(io_wen), .io_ren(io_ren), .io_adr(io_adr),
    .io_wdt(io_wdt), .io_msk(io_msk), .io_rdt(io_rdt), .uart_txd(uart_txd),
    .uart_rxd(uart_rxd), .irq_tx(irq_tx), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    chk_pend <= drv_chk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every bus cycle's expected io_rdt is compared one cycle later.
  always @(negedge clk) begin
    if (chk_pend) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 8'h01, 8'h00);
      else check(name_q.pop_front(), io_rdt, exp_q.pop_front());
    end
  end

  task automatic bus(input logic wen, input logic ren, input logic [5:0] adr,
                     input logic [7:0] wdt, input logic [7:0] msk,
                     input logic [7:0] exp, input string name);
    @(negedge clk);
    io_wen = wen; io_ren = ren; io_adr = adr; io_wdt = wdt; io_msk = msk;
    drv_chk = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    io_wen = 1'b0; io_ren = 1'b0; drv_chk = 1'b0;
  endtask

  task automatic wr(input logic [5:0] adr, input logic [7:0] wdt, input logic [7:0] msk);
    bus(1'b1, 1'b0, adr, wdt, msk, 8'h00, $sformatf("rdt_after_wr_%02h", adr));
  endtask

  task automatic rd(input logic [5:0] adr, input logic [7:0] exp, input string name);
    bus(1'b0, 1'b1, adr, 8'h00, 8'h00, exp, name);
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Drives one 8N1 frame, 8 clocks per bit (BDR=7), LSB first.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (8) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (8) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [15];
    logic [7:0] tx_byte;
    logic       found;
    int         t0;

    vecs[0]  = '{1'b0, 1'b1, A_STA, 8'h00, 8'h00, 8'h02, "reset_sta"};
    vecs[1]  = '{1'b0, 1'b1, A_BDR, 8'h00, 8'h00, 8'h0F, "reset_bdr"};
    vecs[2]  = '{1'b0, 1'b1, A_CTL, 8'h00, 8'h00, 8'h00, "reset_ctl"};
    vecs[3]  = '{1'b1, 1'b0, A_CTL, 8'hFF, 8'h04, 8'h00, "rdt_zero_no_ren"};
    vecs[4]  = '{1'b0, 1'b1, A_CTL, 8'h00, 8'h00, 8'h04, "ctl_masked_write"};
    vecs[5]  = '{1'b0, 1'b1, 6'h14, 8'h00, 8'h00, 8'h00, "unmapped_base_p4"};
    vecs[6]  = '{1'b0, 1'b1, 6'h0F, 8'h00, 8'h00, 8'h00, "unmapped_base_m1"};
    vecs[7]  = '{1'b0, 1'b1, A_DAT, 8'h00, 8'h00, 8'h00, "dat_rx_empty"};
    vecs[8]  = '{1'b1, 1'b0, A_BDR, 8'h03, 8'hFF, 8'h00, "bdr_write"};
    vecs[9]  = '{1'b1, 1'b1, A_BDR, 8'h05, 8'h0F, 8'h03, "wr_rd_same_cycle_old"};
    vecs[10] = '{1'b0, 1'b1, A_BDR, 8'h00, 8'h00, 8'h05, "wr_rd_same_cycle_new"};
    vecs[11] = '{1'b1, 1'b0, A_BDR, 8'hA3, 8'hF0, 8'h00, "bdr_masked_write"};
    vecs[12] = '{1'b0, 1'b1, A_BDR, 8'h00, 8'h00, 8'hA5, "bdr_masked_result"};
    vecs[13] = '{1'b1, 1'b0, A_DAT, 8'h77, 8'h00, 8'h00, "dat_write_zero_mask"};
    vecs[14] = '{1'b0, 1'b1, A_STA, 8'h00, 8'h00, 8'h02, "zero_mask_no_push"};

    rst = 1'b0; io_wen = 1'b0; io_ren = 1'b0; io_adr = '0; io_wdt = '0; io_msk = '0;
    uart_rxd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_txd", {7'b0, uart_txd}, 8'h01);
    check("reset_irq", {6'b0, irq_tx, irq_rx}, 8'h00);
    check("reset_rdt", io_rdt, 8'h00);
    rst = 1'b1;

    for (int i = 0; i < 15; i++)
      bus(vecs[i].wen, vecs[i].ren, vecs[i].adr, vecs[i].wdt, vecs[i].msk, vecs[i].exp, vecs[i].name);

    // Single TX frame, BDR=3: 4 clocks per bit.
    wr(A_BDR, 8'h03, 8'hFF);
    wr(A_CTL, 8'h01, 8'hFF);
    wr(A_DAT, 8'hA5, 8'hFF);
    tx_byte = 8'hA5;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) found = 1'b1;
    end
    check("tx_start_seen", {7'b0, found}, 8'h01);
    t0 = cyc;
    rd(A_STA, 8'h22, "sta_tx_busy");
    wait_neg(t0 + 3);
    check("tx_start_last_cycle", {7'b0, uart_txd}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      wait_neg(t0 + 4 * (k + 1) + 1);
      check($sformatf("tx_bit%0d", k), {7'b0, uart_txd}, {7'b0, tx_byte[k]});
    end
    wait_neg(t0 + 37);
    check("tx_stop", {7'b0, uart_txd}, 8'h01);
    wait_neg(t0 + 40);
    rd(A_STA, 8'h02, "sta_tx_done");

    // TX FIFO fill and overflow with txen off, then drain with tie.
    wr(A_CTL, 8'h00, 8'hFF);
    for (int i = 0; i < 4; i++) wr(A_DAT, 8'h10 + 8'(i), 8'hFF);
    rd(A_STA, 8'h01, "sta_full_no_ovf");
    wr(A_DAT, 8'hEE, 8'hFF);
    rd(A_STA, 8'h41, "sta_tx_ovf");
    wr(A_STA, 8'h40, 8'h40);
    rd(A_STA, 8'h01, "sta_ovf_cleared");
    wr(A_CTL, 8'h05, 8'hFF);
    @(negedge clk);
    check("irq_tx_while_full", {7'b0, irq_tx}, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (irq_tx === 1'b1) found = 1'b1;
    end
    check("irq_tx_on_empty", {7'b0, found}, 8'h01);
    repeat (60) @(negedge clk);
    rd(A_STA, 8'h02, "sta_tx_drained");
    wr(A_CTL, 8'h00, 8'hFF);
    repeat (2) @(negedge clk);
    check("irq_tx_tie_off", {7'b0, irq_tx}, 8'h00);

    // RX single byte with rie at BDR=7.
    wr(A_BDR, 8'h07, 8'hFF);
    wr(A_CTL, 8'h0A, 8'hFF);
    send_byte(8'h3C, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (irq_rx === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check("irq_rx_raised", {7'b0, found}, 8'h01);
    rd(A_DAT, 8'h3C, "rx_byte_3c");
    repeat (2) @(negedge clk);
    check("irq_rx_after_pop", {7'b0, irq_rx}, 8'h00);
    rd(A_STA, 8'h02, "sta_rx_empty");

    // Framing error, then overrun with RFD+1 unread frames.
    send_byte(8'h55, 1'b0);
    repeat (12) @(negedge clk);
    rd(A_STA, 8'h12, "sta_frm_err");
    wr(A_STA, 8'h10, 8'hFF);
    rd(A_STA, 8'h02, "sta_frm_cleared");
    for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1), 1'b1);
    repeat (12) @(negedge clk);
    check("irq_rx_full", {7'b0, irq_rx}, 8'h01);
    rd(A_STA, 8'h0E, "sta_rx_ovr");
    for (int i = 0; i < 4; i++) rd(A_DAT, 8'h11 * 8'(i + 1), $sformatf("rx_fifo_%0d", i));
    rd(A_DAT, 8'h00, "dat_empty_after_drain");
    rd(A_STA, 8'h0A, "sta_ovr_sticky");
    wr(A_STA, 8'h08, 8'h08);
    rd(A_STA, 8'h02, "sta_ovr_cleared");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
